// File: rtl/blasys_eval_pkg.sv
// Shared types and width helpers for the partition evaluation blocks.
// Imported by the metric stage and the sweep monitor top level.
package blasys_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    // Bits needed to hold the popcount of one OUT_W-bit difference word
    function automatic int hd_w(input int out_w);
        return $clog2(out_w + 1);
    endfunction

    function automatic int hd_sum_w(input int in_w, input int out_w);
        return in_w + $clog2(out_w + 1);
    endfunction

    function automatic int abs_sum_w(input int in_w, input int out_w);
        return in_w + out_w;
    endfunction

endpackage

// File: rtl/err_metric_stage.sv
// Stage 1 of the scoring pipeline: per-vector mismatch flag, Hamming
// distance and absolute numeric error, registered together with a valid bit.
module err_metric_stage
    import blasys_eval_pkg::*;
#(
    parameter int OUT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   in_valid,
    input  logic [OUT_W-1:0]       po_exact,
    input  logic [OUT_W-1:0]       po_approx,
    output logic                   diff_nz,
    output logic [hd_w(OUT_W)-1:0] hd,
    output logic [OUT_W-1:0]       absd,
    output logic                   valid
);

    localparam int HD_W = hd_w(OUT_W);

    function automatic logic [HD_W-1:0] popcount(input logic [OUT_W-1:0] x);
        logic [HD_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < OUT_W; i++) begin
            cnt = cnt + HD_W'(x[i]);
        end
        return cnt;
    endfunction

    logic [OUT_W-1:0] xor_s;
    logic [HD_W-1:0]  hd_s;
    logic [OUT_W-1:0] absd_s;

    logic             diff_nz_r;
    logic [HD_W-1:0]  hd_r;
    logic [OUT_W-1:0] absd_r;
    logic             valid_r;

    // Combinational metrics of the current response pair
    always_comb begin
        xor_s = po_exact ^ po_approx;
        hd_s  = popcount(xor_s);
        // Subtracting the smaller from the larger keeps the magnitude exact in OUT_W bits
        if (po_exact >= po_approx) begin
            absd_s = po_exact - po_approx;
        end else begin
            absd_s = po_approx - po_exact;
        end
    end

    // Stage-1 register; cleared when a new sweep is launched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_nz_r <= 1'b0;
            hd_r      <= '0;
            absd_r    <= '0;
            valid_r   <= 1'b0;
        end else if (clr) begin
            diff_nz_r <= 1'b0;
            hd_r      <= '0;
            absd_r    <= '0;
            valid_r   <= 1'b0;
        end else begin
            diff_nz_r <= |xor_s;
            hd_r      <= hd_s;
            absd_r    <= absd_s;
            valid_r   <= in_valid;
        end
    end

    assign diff_nz = diff_nz_r;
    assign hd      = hd_r;
    assign absd    = absd_r;
    assign valid   = valid_r;

endmodule

// File: rtl/partition_sweep_monitor.sv
// Exhaustive sweep of one partition's input space, scoring the approximate
// netlist against the exact one: error count, Hamming sum, abs-error sum and max.
module partition_sweep_monitor
    import blasys_eval_pkg::*;
#(
    parameter int IN_W  = 7,
    parameter int OUT_W = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic [IN_W-1:0]                     pi,
    input  logic [OUT_W-1:0]                    po_exact,
    input  logic [OUT_W-1:0]                    po_approx,
    output logic                                busy,
    output logic                                done,
    output logic [IN_W:0]                       err_count,
    output logic [hd_sum_w(IN_W, OUT_W)-1:0]    hd_sum,
    output logic [abs_sum_w(IN_W, OUT_W)-1:0]   abs_sum,
    output logic [OUT_W-1:0]                    abs_max
);

    localparam int ERR_W = IN_W + 1;
    localparam int HD_W  = hd_w(OUT_W);
    localparam int HDS_W = hd_sum_w(IN_W, OUT_W);
    localparam int ABS_W = abs_sum_w(IN_W, OUT_W);

    sweep_state_t     state_r;
    sweep_state_t     state_nxt_s;
    logic [IN_W-1:0]  pi_r;
    logic             busy_r;
    logic             done_r;
    logic [ERR_W-1:0] err_r;
    logic [HDS_W-1:0] hd_sum_r;
    logic [ABS_W-1:0] abs_sum_r;
    logic [OUT_W-1:0] abs_max_r;

    logic             start_sweep_s;
    logic             last_vec_s;
    logic             stg_diff_nz_s;
    logic [HD_W-1:0]  stg_hd_s;
    logic [OUT_W-1:0] stg_absd_s;
    logic             stg_valid_s;

    assign start_sweep_s = (state_r == IDLE) && start;
    assign last_vec_s    = (pi_r == {IN_W{1'b1}});

    // Next-state logic of the sweep controller
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = SWEEP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SWEEP: begin
                if (last_vec_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = SWEEP;
                end
            end
            DRAIN:   state_nxt_s = DONE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, vector counter and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            pi_r    <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            // Natural wrap on the last vector returns pi to 0 for DRAIN
            if (state_r == SWEEP) begin
                pi_r <= pi_r + IN_W'(1);
            end else begin
                pi_r <= '0;
            end
            busy_r <= (state_nxt_s == SWEEP) || (state_nxt_s == DRAIN);
            done_r <= (state_nxt_s == DONE);
        end
    end

    err_metric_stage #(
        .OUT_W (OUT_W)
    ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_sweep_s),
        .in_valid  (state_r == SWEEP),
        .po_exact  (po_exact),
        .po_approx (po_approx),
        .diff_nz   (stg_diff_nz_s),
        .hd        (stg_hd_s),
        .absd      (stg_absd_s),
        .valid     (stg_valid_s)
    );

    // Stage-2 accumulators; cleared by the start edge, otherwise hold when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r     <= '0;
            hd_sum_r  <= '0;
            abs_sum_r <= '0;
            abs_max_r <= '0;
        end else if (start_sweep_s) begin
            err_r     <= '0;
            hd_sum_r  <= '0;
            abs_sum_r <= '0;
            abs_max_r <= '0;
        end else if (stg_valid_s) begin
            err_r     <= err_r + ERR_W'(stg_diff_nz_s);
            hd_sum_r  <= hd_sum_r + HDS_W'(stg_hd_s);
            abs_sum_r <= abs_sum_r + ABS_W'(stg_absd_s);
            if (stg_absd_s > abs_max_r) begin
                abs_max_r <= stg_absd_s;
            end else begin
                abs_max_r <= abs_max_r;
            end
        end else begin
            err_r     <= err_r;
            hd_sum_r  <= hd_sum_r;
            abs_sum_r <= abs_sum_r;
            abs_max_r <= abs_max_r;
        end
    end

    assign pi        = pi_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err_count = err_r;
    assign hd_sum    = hd_sum_r;
    assign abs_sum   = abs_sum_r;
    assign abs_max   = abs_max_r;

endmodule

// File: tb/tb_partition_sweep_monitor.sv
// Bench for partition_sweep_monitor: cycle-level reference model compared every
// cycle, plus hand-computed end-of-sweep results for directed scenarios.
module tb_partition_sweep_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  pi;
    logic [3:0]  po_exact;
    logic [3:0]  po_approx;
    logic        busy;
    logic        done;
    logic [7:0]  err_count;
    logic [9:0]  hd_sum;
    logic [10:0] abs_sum;
    logic [3:0]  abs_max;

    int mode = 0;
    int n_vec = 0;
    int n_fail = 0;

    // Reference model state
    bit m_run = 1'b0;
    int m_k = 0;
    int m_err = 0, m_hd = 0, m_abs = 0, m_max = 0;

    always #5 clk = ~clk;

    partition_sweep_monitor #(.IN_W(7), .OUT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pi        (pi),
        .po_exact  (po_exact),
        .po_approx (po_approx),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .hd_sum    (hd_sum),
        .abs_sum   (abs_sum),
        .abs_max   (abs_max)
    );

    function automatic logic [3:0] resp_exact(input logic [6:0] v);
        return v[3:0];
    endfunction

    function automatic logic [3:0] resp_approx(input int m, input logic [6:0] v);
        case (m)
            0:       return v[3:0];
            1:       return v[3:0] ^ 4'b0001;
            2:       return 4'd0;
            default: return v[6:3];
        endcase
    endfunction

    assign po_exact  = resp_exact(pi);
    assign po_approx = resp_approx(mode, pi);

    // Metrics over the first n vectors of the input space
    task automatic calc(input int m, input int n, output int e, output int h, output int a, output int mx);
        int ex, ap, d;
        e = 0; h = 0; a = 0; mx = 0;
        for (int v = 0; v < n; v++) begin
            ex = int'(resp_exact(7'(v)));
            ap = int'(resp_approx(m, 7'(v)));
            d = ex - ap;
            if (d < 0) d = -d;
            if (d != 0) e++;
            h += $countones(ex ^ ap);
            a += d;
            if (d > mx) mx = d;
        end
    endtask

    task automatic chk(input string name, input longint act, input longint expv);
        n_vec++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Model: cycle k counts from 1 after the start edge; DONE is k=130
    initial begin
        int n;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_run = 1'b0; m_k = 0;
                m_err = 0; m_hd = 0; m_abs = 0; m_max = 0;
            end else if (m_run) begin
                m_k++;
                if (m_k > 130) begin
                    m_run = 1'b0;
                end else begin
                    n = (m_k >= 3) ? ((m_k - 2 > 128) ? 128 : m_k - 2) : 0;
                    calc(mode, n, m_err, m_hd, m_abs, m_max);
                end
            end else if (start) begin
                m_run = 1'b1; m_k = 1;
                m_err = 0; m_hd = 0; m_abs = 0; m_max = 0;
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("pi",        pi,        (m_run && m_k <= 128) ? m_k - 1 : 0);
            chk("busy",      busy,      (m_run && m_k <= 129) ? 1 : 0);
            chk("done",      done,      (m_run && m_k == 130) ? 1 : 0);
            chk("err_count", err_count, m_err);
            chk("hd_sum",    hd_sum,    m_hd);
            chk("abs_sum",   abs_sum,   m_abs);
            chk("abs_max",   abs_max,   m_max);
        end
    end

    task automatic run_sweep(input int m, input int pa, input int pb, input bit hold, output int cyc);
        mode = m;
        start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #2;
            cyc++;
            start = hold || (cyc == pa) || (cyc == pb);
        end while (!done && cyc < 300);
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic check_lit(input string tag, input int cyc, input int cyc_exp,
                             input int e, input int h, input int a, input int mx);
        chk({tag, "_done_cycle"}, cyc, cyc_exp);
        chk({tag, "_err"}, err_count, e);
        chk({tag, "_hd"},  hd_sum, h);
        chk({tag, "_abs"}, abs_sum, a);
        chk({tag, "_max"}, abs_max, mx);
    endtask

    initial begin
        int cyc;
        bit seen;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_err", err_count, 0);
        chk("reset_pi", pi, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        run_sweep(0, 0, 0, 1'b0, cyc);
        check_lit("identical", cyc, 130, 0, 0, 0, 0);
        repeat (3) @(posedge clk); #2;

        run_sweep(1, 0, 0, 1'b0, cyc);
        check_lit("lsb_flip", cyc, 130, 128, 128, 128, 1);
        repeat (3) @(posedge clk); #2;

        run_sweep(2, 0, 0, 1'b0, cyc);
        check_lit("stuck0", cyc, 130, 120, 256, 960, 15);
        repeat (3) @(posedge clk); #2;

        run_sweep(3, 0, 0, 1'b0, cyc);
        chk("hi_bits_done_cycle", cyc, 130);
        repeat (3) @(posedge clk); #2;

        // Mid-sweep start pulses are ignored
        run_sweep(2, 5, 60, 1'b0, cyc);
        check_lit("restart_ignored", cyc, 130, 120, 256, 960, 15);
        repeat (3) @(posedge clk); #2;

        // Reset at cycle 40 aborts the sweep
        mode = 2;
        start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #2; cyc++;
            start = 1'b0;
        end while (cyc < 40);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #2;
            if (done) seen = 1'b1;
        end
        chk("rst_no_done", seen, 0);
        chk("rst_err", err_count, 0);
        chk("rst_abs", abs_sum, 0);
        chk("rst_busy", busy, 0);

        // Back-to-back with start held through DONE
        run_sweep(2, 0, 0, 1'b1, cyc);
        check_lit("b2b_first", cyc, 130, 120, 256, 960, 15);
        mode = 0;
        cyc = 0;
        do begin
            @(posedge clk); #2; cyc++;
            start = (cyc < 2);
        end while (!done && cyc < 300);
        check_lit("b2b_second", cyc, 131, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
